// File: rtl/acc_cmd_issuer.sv
// CPU-side command issuer: accepts one command, runs the 4-phase req/ack handshake
// with the accelerator controller, and returns opsum data through a response register.
module acc_cmd_issuer #(
    parameter int ACK_TIMEOUT = 256,
    parameter int CNT_W       = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_ctrl,
    input  logic [31:0] cmd_data,
    output logic [7:0]  req,
    output logic [31:0] cpu_ctrl,
    output logic [31:0] cpu_data,
    input  logic        ack,
    input  logic [31:0] acc_ctrl,
    input  logic [31:0] acc_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_status,
    output logic        busy,
    output logic        err,
    input  logic        err_clr
);

    typedef enum logic [1:0] {IDLE, REQ, REL, RSP} state_t;

    localparam logic [2:0]       OP_OPSUM = 3'd7;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state;
    logic [2:0]       op;
    logic [CNT_W-1:0] cnt;
    logic             aborted;
    logic             timeout;

    // Only the four status flags are captured; the upper status bits are ignored.
    logic unused_acc_ctrl;
    assign unused_acc_ctrl = ^acc_ctrl[31:4];

    assign timeout = (cnt == CNT_LAST);

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; later assignments in the same edge override earlier ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op         <= '0;
            cnt        <= '0;
            aborted    <= 1'b0;
            req        <= '0;
            cpu_ctrl   <= '0;
            cpu_data   <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_status <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            cmd_ready  <= 1'b1;
        end else begin
            // NOTE: the clear comes first so a timeout set later in this edge wins.
            if (err_clr) err <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cpu_ctrl  <= cmd_ctrl;
                        cpu_data  <= cmd_data;
                        req       <= 8'(1) << cmd_op;
                        op        <= cmd_op;
                        cnt       <= '0;
                        aborted   <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= REQ;
                    end
                end

                REQ: begin
                    if (ack) begin
                        req   <= '0;
                        cnt   <= '0;
                        state <= REL;
                        // acc_data was refreshed on the previous edge, so it is current here.
                        if (op == OP_OPSUM) begin
                            rsp_data   <= acc_data;
                            rsp_status <= acc_ctrl[3:0];
                        end
                    end else if (timeout) begin
                        req     <= '0;
                        cnt     <= '0;
                        err     <= 1'b1;
                        aborted <= 1'b1;
                        state   <= REL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                REL: begin
                    if (!ack || timeout) begin
                        cpu_ctrl <= '0;
                        cpu_data <= '0;
                        cnt      <= '0;
                        if (!ack && op == OP_OPSUM && !aborted) begin
                            rsp_valid <= 1'b1;
                            state     <= RSP;
                        end else begin
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                        if (ack) err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_cmd_issuer.sv
// Self-checking bench for acc_cmd_issuer: a table of commands through a scripted
// controller, plus hand-written timeout, stuck-ack and mid-operation reset sequences.
module tb_acc_cmd_issuer;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_ctrl;
    logic [31:0] cmd_data;
    logic [7:0]  req;
    logic [31:0] cpu_ctrl;
    logic [31:0] cpu_data;
    logic        ack;
    logic [31:0] acc_ctrl;
    logic [31:0] acc_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_status;
    logic        busy;
    logic        err;
    logic        err_clr;

    acc_cmd_issuer #(.ACK_TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ctrl(cmd_ctrl), .cmd_data(cmd_data),
        .req(req), .cpu_ctrl(cpu_ctrl), .cpu_data(cpu_data),
        .ack(ack), .acc_ctrl(acc_ctrl), .acc_data(acc_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_status(rsp_status),
        .busy(busy), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] ctrl;
        logic [31:0] data;
        logic [31:0] acc_d;
        logic [31:0] acc_c;
        logic [7:0]  exp_req;
        logic [3:0]  exp_status;
        int          hold;
    } vec_t;

    vec_t        vecs [8];
    logic [7:0]  exp_req_q [$];
    logic [35:0] exp_rsp_q [$];
    int          checks = 0;
    int          errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Accept on the current cycle T; bench is at T+1 on return.
    task automatic accept(input logic [2:0] op, input logic [31:0] c, input logic [31:0] d,
                          input logic [7:0] exp_req);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_ctrl = c; cmd_data = d;
        exp_req_q.push_back(exp_req);
        tick();
        cmd_valid = 1'b0; cmd_ctrl = 32'hFFFF_FFFF; cmd_data = 32'hFFFF_FFFF;
        if (exp_req_q.size() == 0) check("req_queue", 32'd0, 32'd1);
        else check("req_after_accept", 32'(req), 32'(exp_req_q.pop_front()));
        check("req_onehot", 32'($countones(req)), 32'd1);
        check("busy_active", 32'(busy), 32'd1);
        check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    endtask

    // Controller script: ack high for cycles T+2..T+4, low from T+5.
    task automatic run_vec(input vec_t v);
        accept(v.op, v.ctrl, v.data, v.exp_req);
        tick();                                          // T+2
        ack = 1'b1; acc_data = v.acc_d; acc_ctrl = v.acc_c;
        if (v.op == 3'd7) exp_rsp_q.push_back({v.exp_status, v.acc_d});
        check("req_second_cycle", 32'(req), 32'(v.exp_req));
        check("cpu_ctrl_held", cpu_ctrl, v.ctrl);
        check("cpu_data_held", cpu_data, v.data);
        tick();                                          // T+3
        acc_data = 32'h5555_5555; acc_ctrl = 32'h0;
        check("req_dropped", 32'(req), 32'd0);
        check("cpu_data_rel", cpu_data, v.data);
        tick();                                          // T+4
        tick();                                          // T+5
        ack = 1'b0;
        check("cmd_ready_t5", 32'(cmd_ready), 32'd0);
        tick();                                          // T+6
        check("cpu_ctrl_cleared", cpu_ctrl, 32'd0);
        check("cpu_data_cleared", cpu_data, 32'd0);
        if (v.op != 3'd7) begin
            check("cmd_ready_t6", 32'(cmd_ready), 32'd1);
            check("busy_t6", 32'(busy), 32'd0);
            check("no_rsp", 32'(rsp_valid), 32'd0);
        end else begin
            check("rsp_valid_t6", 32'(rsp_valid), 32'd1);
            for (int i = 0; i < v.hold; i++) begin
                tick();
                check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
                check("cmd_ready_rsp", 32'(cmd_ready), 32'd0);
            end
            rsp_ready = 1'b1;
            if (rsp_valid && exp_rsp_q.size() > 0) begin
                logic [35:0] e;
                e = exp_rsp_q.pop_front();
                check("rsp_data", rsp_data, e[31:0]);
                check("rsp_status", 32'(rsp_status), 32'(e[35:32]));
            end else begin
                check("rsp_available", 32'(rsp_valid), 32'd1);
            end
            tick();
            rsp_ready = 1'b0;
            check("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
            check("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
            check("rsp_data_retained", rsp_data, v.acc_d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'd0, 32'h0000_0001, 32'h1111_0000, 32'h0, 32'h0, 8'h01, 4'h0, 0};
        vecs[1] = '{3'd1, 32'h0000_0002, 32'h2222_0000, 32'h0, 32'h0, 8'h02, 4'h0, 0};
        vecs[2] = '{3'd2, 32'h0000_0003, 32'h3333_0000, 32'h0, 32'h0, 8'h04, 4'h0, 0};
        vecs[3] = '{3'd3, 32'h8000_0004, 32'h4444_0000, 32'h0, 32'h0, 8'h08, 4'h0, 0};
        vecs[4] = '{3'd4, 32'h0000_0123, 32'hDEAD_BEEF, 32'h0, 32'h0, 8'h10, 4'h0, 0};
        vecs[5] = '{3'd5, 32'h0000_0006, 32'h6666_0000, 32'h0, 32'h0, 8'h20, 4'h0, 0};
        vecs[6] = '{3'd6, 32'h0000_0007, 32'h7777_0000, 32'h0, 32'h0, 8'h40, 4'h0, 0};
        vecs[7] = '{3'd7, 32'h0000_0008, 32'h8888_0000, 32'h0000_00AB, 32'h0000_0091, 8'h80, 4'h1, 5};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_ctrl = '0; cmd_data = '0;
        ack = 1'b0; acc_ctrl = '0; acc_data = '0; rsp_ready = 1'b0; err_clr = 1'b0;
        tick(); tick(); tick();
        check("rst_req", 32'(req), 32'd0);
        check("rst_cpu_ctrl", cpu_ctrl, 32'd0);
        check("rst_cpu_data", cpu_data, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_status", 32'(rsp_status), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Ack never rises: req high for TO cycles, then abort through REL.
        accept(3'd2, 32'h0000_00C2, 32'h0000_00D2, 8'h04);
        for (int i = 1; i < TO; i++) begin
            tick();
            check("req_waiting", 32'(req), 32'h04);
            check("err_pending", 32'(err), 32'd0);
        end
        tick();
        check("req_timeout_drop", 32'(req), 32'd0);
        check("err_req_timeout", 32'(err), 32'd1);
        tick();
        check("idle_after_abort", 32'(cmd_ready), 32'd1);
        check("no_rsp_abort", 32'(rsp_valid), 32'd0);
        tick();
        check("err_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_cleared", 32'(err), 32'd0);

        // Ack stuck high in REL for op=7; err_clr on the timeout edge loses to the set.
        accept(3'd7, 32'h0000_0077, 32'h0000_0088, 8'h80);
        tick();                                          // T+2
        ack = 1'b1; acc_data = 32'h0000_00CD; acc_ctrl = 32'h0000_000F;
        tick();                                          // T+3, REL count 0
        for (int i = 1; i < TO; i++) begin
            tick();
            check("err_rel_pending", 32'(err), 32'd0);
        end                                              // T+10, REL count TO-1
        err_clr = 1'b1;
        tick();                                          // T+11
        err_clr = 1'b0;
        check("err_rel_timeout", 32'(err), 32'd1);
        check("idle_after_rel_to", 32'(cmd_ready), 32'd1);
        check("busy_after_rel_to", 32'(busy), 32'd0);
        ack = 1'b0;
        tick();
        check("no_rsp_stuck", 32'(rsp_valid), 32'd0);
        tick();
        check("no_rsp_stuck_late", 32'(rsp_valid), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Reset while in REQ.
        accept(3'd5, 32'h0000_0055, 32'h0000_0066, 8'h20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_req", 32'(req), 32'd0);
        check("mid_rst_cpu_ctrl", cpu_ctrl, 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);

        run_vec(vecs[4]);

        check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
        check("rsp_queue_drained", 32'(exp_rsp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
